lpc_capture_ctrl: RTL and testbench

Capture controller between the LPC record path (bufferdomain output) and the ringbuffer write port. It arms on command, waits for a trigger record matching a cycle type and masked address, then forwards the trigger record plus a programmed number of follow-on records. Records dropped because the ring is full are counted. Under `LPC_CAPTURE_MARKER_EN`, a marker record carrying the drop count is written into the same port on an idle cycle.

---
 rtl/lpc_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lpc_capture_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lpc_capture_ctrl.sv
// lpc_capture_ctrl
//   Capture controller between the LPC record path and the ringbuffer write
//   port. After an arm pulse it waits for a trigger record whose cycle type
//   and masked address match, then forwards the trigger record plus
//   post_count follow-on records. Records that are selected for writing while
//   the ring is full are dropped and counted in drop_total (saturating).
//
//   Optional feature macro: LPC_CAPTURE_MARKER_EN
//     When defined, drops also accumulate in a pending count. On a cycle with
//     no incoming record and ring space, a marker record
//     {pending, 8'h00, 3'b111, 5'b00000} is written and pending clears.
//
// Ports
//   clock, reset         single clock, asynchronous active-low reset
//   in_data, in_enable   record from bufferdomain and its one-cycle strobe
//   ring_full            ring cannot accept a write this cycle
//   out_data, out_enable registered record and write strobe to the ring
//   arm                  one-cycle pulse, (re)start capture
//   match_cyctype/addr/mask, post_count   trigger setup, held stable while armed
//   state                IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   drop_total           saturating drop count since last arm
module lpc_capture_ctrl #(
  parameter int DW    = 48,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DW-1:0]    in_data,
  input  logic             in_enable,
  input  logic             ring_full,
  output logic [DW-1:0]    out_data,
  output logic             out_enable,
  input  logic             arm,
  input  logic [3:0]       match_cyctype,
  input  logic [31:0]      match_addr,
  input  logic [31:0]      match_mask,
  input  logic [CNT_W-1:0] post_count,
  output logic [1:0]       state,
  output logic [31:0]      drop_total
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      drop_total_q, drop_total_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_enable_q, out_enable_d;

  logic             match_hit;
  logic             write_sel;
  logic             drop;
  logic             marker_emit;
  logic [DW-1:0]    marker_rec;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Record selection: arm in the same cycle suppresses the record entirely.
  always_comb begin
    match_hit = (in_data[3:0] == match_cyctype) &&
                (((in_data[47:16] ^ match_addr) & match_mask) == 32'd0);
    write_sel = in_enable && !arm &&
                (((state_q == S_ARMED) && match_hit) || (state_q == S_CAPTURE));
    drop      = write_sel && ring_full;
  end

`ifdef LPC_CAPTURE_MARKER_EN
  logic [31:0] pending_q, pending_d;

  // A marker only uses the port when no record arrives, so it never
  // competes with a forwarded record and never coincides with a drop.
  always_comb begin
    marker_emit = (pending_q != 32'd0) && !ring_full && !in_enable;
    marker_rec  = {pending_q, 8'h00, 3'b111, 5'b00000};
    pending_d   = pending_q;
    if (marker_emit) pending_d = 32'd0;
    else if (drop)   pending_d = sat_inc32(pending_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending_q <= 32'd0;
    else        pending_q <= pending_d;
  end
`else
  always_comb begin
    marker_emit = 1'b0;
    marker_rec  = '0;
  end
`endif

  // Drop accounting; arm restarts the count.
  always_comb begin
    drop_total_d = drop_total_q;
    if (arm)       drop_total_d = 32'd0;
    else if (drop) drop_total_d = sat_inc32(drop_total_q);
  end

  // FSM state register (plus the registered datapath it drives).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      drop_total_q <= 32'd0;
      out_data_q   <= '0;
      out_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      drop_total_q <= drop_total_d;
      out_data_q   <= out_data_d;
      out_enable_q <= out_enable_d;
    end
  end

  // FSM next state. Capture length counts records seen, dropped or not.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (arm) begin
      state_d = S_ARMED;
    end else if (in_enable) begin
      case (state_q)
        S_ARMED: begin
          if (match_hit) begin
            remaining_d = post_count;
            state_d     = (post_count == '0) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (remaining_q <= {{(CNT_W-1){1'b0}}, 1'b1}) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // FSM outputs: LPC record has priority over a marker on the write port.
  always_comb begin
    out_enable_d = 1'b0;
    out_data_d   = out_data_q;
    if (write_sel) begin
      out_enable_d = !ring_full;
      if (!ring_full) out_data_d = in_data;
    end else if (marker_emit) begin
      out_enable_d = 1'b1;
      out_data_d   = marker_rec;
    end
  end

  assign out_data   = out_data_q;
  assign out_enable = out_enable_q;
  assign state      = state_q;
  assign drop_total = drop_total_q;

endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// Directed testbench for lpc_capture_ctrl. Inputs change on the falling edge;
// outputs are sampled 1 time unit after the rising edge that consumed them.
// Marker expectations follow LPC_CAPTURE_MARKER_EN.
module tb_lpc_capture_ctrl;
  localparam int DW    = 48;
  localparam int CNT_W = 16;
`ifdef LPC_CAPTURE_MARKER_EN
  localparam logic MK = 1'b1;
`else
  localparam logic MK = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [DW-1:0]    in_data;
  logic             in_enable;
  logic             ring_full;
  logic [DW-1:0]    out_data;
  logic             out_enable;
  logic             arm;
  logic [3:0]       match_cyctype;
  logic [31:0]      match_addr;
  logic [31:0]      match_mask;
  logic [CNT_W-1:0] post_count;
  logic [1:0]       state;
  logic [31:0]      drop_total;

  int checks = 0;
  int errors = 0;

  lpc_capture_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_enable(in_enable),
    .ring_full(ring_full), .out_data(out_data), .out_enable(out_enable),
    .arm(arm), .match_cyctype(match_cyctype), .match_addr(match_addr),
    .match_mask(match_mask), .post_count(post_count), .state(state),
    .drop_total(drop_total)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] rec(input logic [31:0] a);
    return {a, 8'hA5, 3'b000, 1'b0, 4'b0100};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 1 unit after the consuming edge.
  task automatic step(input logic en, input logic [31:0] a, input logic full, input logic ar);
    @(negedge clock);
    in_enable = en;
    in_data   = en ? rec(a) : '0;
    ring_full = full;
    arm       = ar;
    @(posedge clock);
    #1;
    in_enable = 1'b0;
    ring_full = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic expect_wr(input string tag, input logic [31:0] a);
    chk({tag, "_oe"}, {47'd0, out_enable}, 48'd1);
    chk({tag, "_data"}, out_data, rec(a));
  endtask

  initial begin
    reset = 1'b0; in_data = '0; in_enable = 1'b0; ring_full = 1'b0; arm = 1'b0;
    match_cyctype = 4'b0100; match_addr = 32'h3F8; match_mask = 32'hFFFF_FFFF;
    post_count = 16'd2;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", {46'd0, state}, 48'd0);
    chk("rst_oe", {47'd0, out_enable}, 48'd0);
    chk("rst_data", out_data, 48'd0);
    chk("rst_drop", {16'd0, drop_total}, 48'd0);
    @(negedge clock);
    reset = 1'b1;

    // Basic capture
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("basic_armed", {46'd0, state}, 48'd1);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    chk("basic_nomatch_oe", {47'd0, out_enable}, 48'd0);
    chk("basic_nomatch_state", {46'd0, state}, 48'd1);
    step(1'b1, 32'h3F8, 1'b0, 1'b0);
    expect_wr("basic_trig", 32'h3F8);
    chk("basic_state_cap", {46'd0, state}, 48'd2);
    step(1'b1, 32'h3F9, 1'b0, 1'b0);
    expect_wr("basic_p1", 32'h3F9);
    step(1'b1, 32'h3FA, 1'b0, 1'b0);
    expect_wr("basic_p2", 32'h3FA);
    chk("basic_state_done", {46'd0, state}, 48'd3);
    step(1'b1, 32'h3FB, 1'b0, 1'b0);
    chk("basic_after_done_oe", {47'd0, out_enable}, 48'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("basic_idle_oe", {47'd0, out_enable}, 48'd0);

    // Masked match, zero post count
    match_mask = 32'hFFFF_FFF0; post_count = 16'd0;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("mask_armed", {46'd0, state}, 48'd1);
    step(1'b1, 32'h3FC, 1'b0, 1'b0);
    expect_wr("mask_trig", 32'h3FC);
    chk("mask_state_done", {46'd0, state}, 48'd3);
    step(1'b1, 32'h3F8, 1'b0, 1'b0);
    chk("mask_after_oe", {47'd0, out_enable}, 48'd0);

    // Overflow with markers, then arbitration
    match_mask = 32'hFFFF_FFFF; post_count = 16'd8;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h3F8, 1'b0, 1'b0);
    expect_wr("ovf_trig", 32'h3F8);
    step(1'b1, 32'h500, 1'b1, 1'b0);
    chk("ovf_d1_oe", {47'd0, out_enable}, 48'd0);
    chk("ovf_d1_cnt", {16'd0, drop_total}, 48'd1);
    step(1'b1, 32'h501, 1'b1, 1'b0);
    chk("ovf_d2_cnt", {16'd0, drop_total}, 48'd2);
    step(1'b1, 32'h502, 1'b1, 1'b0);
    chk("ovf_d3_oe", {47'd0, out_enable}, 48'd0);
    chk("ovf_d3_cnt", {16'd0, drop_total}, 48'd3);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ovf_marker_oe", {47'd0, out_enable}, {47'd0, MK});
`ifdef LPC_CAPTURE_MARKER_EN
    chk("ovf_marker_data", out_data, {32'd3, 8'h00, 3'b111, 5'b00000});
`endif
    chk("ovf_drop_total", {16'd0, drop_total}, 48'd3);
    chk("ovf_state", {46'd0, state}, 48'd2);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ovf_single_marker", {47'd0, out_enable}, 48'd0);

    // remaining is now 5; one more drop leaves 4 and pending=1
    step(1'b1, 32'h503, 1'b1, 1'b0);
    chk("arb_drop_cnt", {16'd0, drop_total}, 48'd4);
    step(1'b1, 32'h600, 1'b0, 1'b0);
    expect_wr("arb_r0", 32'h600);
    step(1'b1, 32'h601, 1'b0, 1'b0);
    expect_wr("arb_r1", 32'h601);
    step(1'b1, 32'h602, 1'b0, 1'b0);
    expect_wr("arb_r2", 32'h602);
    step(1'b1, 32'h603, 1'b0, 1'b0);
    expect_wr("arb_r3", 32'h603);
    chk("arb_state_done", {46'd0, state}, 48'd3);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("arb_marker_oe", {47'd0, out_enable}, {47'd0, MK});
`ifdef LPC_CAPTURE_MARKER_EN
    chk("arb_marker_data", out_data, {32'd1, 8'h00, 3'b111, 5'b00000});
`endif

    // Arm collision
    post_count = 16'd1;
    step(1'b1, 32'h3F8, 1'b0, 1'b1);
    chk("coll_oe", {47'd0, out_enable}, 48'd0);
    chk("coll_state", {46'd0, state}, 48'd1);
    chk("coll_drop_clr", {16'd0, drop_total}, 48'd0);
    step(1'b1, 32'h3F8, 1'b0, 1'b0);
    expect_wr("coll_trig", 32'h3F8);
    chk("coll_state_cap", {46'd0, state}, 48'd2);
    step(1'b1, 32'h3F9, 1'b0, 1'b0);
    expect_wr("coll_p1", 32'h3F9);
    chk("coll_state_done", {46'd0, state}, 48'd3);

    // Async reset mid-capture
    post_count = 16'd3;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h3F8, 1'b0, 1'b0);
    step(1'b1, 32'h3F9, 1'b1, 1'b0);
    chk("ar_drop_pre", {16'd0, drop_total}, 48'd1);
    step(1'b1, 32'h3FA, 1'b0, 1'b0);
    expect_wr("ar_pre_wr", 32'h3FA);
    chk("ar_pre_state", {46'd0, state}, 48'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_state", {46'd0, state}, 48'd0);
    chk("ar_oe", {47'd0, out_enable}, 48'd0);
    chk("ar_drop", {16'd0, drop_total}, 48'd0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 32'h3FB, 1'b0, 1'b0);
    chk("ar_post_oe0", {47'd0, out_enable}, 48'd0);
    chk("ar_post_state", {46'd0, state}, 48'd0);
    step(1'b1, 32'h3F8, 1'b0, 1'b0);
    chk("ar_post_oe1", {47'd0, out_enable}, 48'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ar_no_marker", {47'd0, out_enable}, 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
